// File: rtl/data_memory_responder.sv
// Data-memory responder for the MEM stage: accepts one load/store, stalls via
// BUSYWAIT for LATENCY cycles, then commits the store or returns extended load data.
module data_memory_responder #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LATENCY    = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITEDATA,
    input  logic [2:0]  LOADSIGNAL,
    input  logic [1:0]  STORESIGNAL,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT,
    output logic        MISALIGN
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned BA_W   = ADDR_WIDTH + 2;
    localparam int unsigned CNT_W  = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_write_q, is_write_d;
    logic [BA_W-1:0]    addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [2:0]         lsig_q, lsig_d;
    logic [1:0]         ssig_q, ssig_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               misalign_q, misalign_d;

    logic [31:0]        mem_q [DEPTH];

    logic               req_c;
    logic               use_live_c;
    logic               cur_write_c;
    logic [BA_W-1:0]    cur_addr_c;
    logic [31:0]        cur_wdata_c;
    logic [2:0]         cur_lsig_c;
    logic [1:0]         cur_ssig_c;
    logic               commit_c;
    logic               is_byte_c;
    logic               is_half_c;
    logic               is_word_c;
    logic               mis_c;
    logic [31:0]        word_c;
    logic [7:0]         byte_c;
    logic [15:0]        half_c;
    logic [31:0]        load_val_c;
    logic [3:0]         be_c;
    logic [31:0]        wrep_c;
    logic [31:0]        merged_c;
    logic               mem_we_c;

    // Upper address bits are ignored: the array wraps.
    logic               unused_addr;
    assign unused_addr = &{1'b0, ADDRESS[31:BA_W]};

    // Request detect and commit-operand selection (live inputs on the accept edge).
    always_comb begin
        req_c       = READ | WRITE;
        use_live_c  = (state_q == IDLE);
        cur_write_c = use_live_c ? WRITE                : is_write_q;
        cur_addr_c  = use_live_c ? ADDRESS[BA_W-1:0]    : addr_q;
        cur_wdata_c = use_live_c ? WRITEDATA            : wdata_q;
        cur_lsig_c  = use_live_c ? LOADSIGNAL           : lsig_q;
        cur_ssig_c  = use_live_c ? STORESIGNAL          : ssig_q;
        commit_c    = RESET &&
                      (((state_q == IDLE) && req_c && (LATENCY == 1)) ||
                       ((state_q == ACCESS) && (cnt_q == CNT_W'(LATENCY - 1))));
    end

    // Access size and misalignment check.
    always_comb begin
        is_byte_c = 1'b0;
        is_half_c = 1'b0;
        if (cur_write_c) begin
            is_byte_c = (cur_ssig_c == 2'd1);
            is_half_c = (cur_ssig_c == 2'd2);
        end else begin
            is_byte_c = (cur_lsig_c == 3'd1) || (cur_lsig_c == 3'd4);
            is_half_c = (cur_lsig_c == 3'd2) || (cur_lsig_c == 3'd5);
        end
        is_word_c = !is_byte_c && !is_half_c;
        mis_c     = (is_half_c && cur_addr_c[0]) ||
                    (is_word_c && (cur_addr_c[1:0] != 2'b00));
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        word_c = mem_q[cur_addr_c[BA_W-1:2]];
        byte_c = 8'(word_c >> {cur_addr_c[1:0], 3'b000});
        half_c = cur_addr_c[1] ? word_c[31:16] : word_c[15:0];
        case (cur_lsig_c)
            3'd1:    load_val_c = {{24{byte_c[7]}}, byte_c};
            3'd2:    load_val_c = {{16{half_c[15]}}, half_c};
            3'd4:    load_val_c = {24'd0, byte_c};
            3'd5:    load_val_c = {16'd0, half_c};
            default: load_val_c = word_c;
        endcase
    end

    // Store byte-enable generation and merge with the existing word.
    always_comb begin
        case (cur_ssig_c)
            2'd1: begin
                be_c   = 4'(4'b0001 << cur_addr_c[1:0]);
                wrep_c = {4{cur_wdata_c[7:0]}};
            end
            2'd2: begin
                be_c   = cur_addr_c[1] ? 4'b1100 : 4'b0011;
                wrep_c = {2{cur_wdata_c[15:0]}};
            end
            default: begin
                be_c   = 4'b1111;
                wrep_c = cur_wdata_c;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            merged_c[i*8 +: 8] = be_c[i] ? wrep_c[i*8 +: 8] : word_c[i*8 +: 8];
        end
        mem_we_c = commit_c && cur_write_c && !mis_c;
    end

    // Next-state, request latching and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lsig_d     = lsig_q;
        ssig_d     = ssig_q;
        rdata_d    = rdata_q;
        misalign_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_c) begin
                    is_write_d = WRITE;
                    addr_d     = ADDRESS[BA_W-1:0];
                    wdata_d    = WRITEDATA;
                    lsig_d     = LOADSIGNAL;
                    ssig_d     = STORESIGNAL;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ACCESS: begin
                if (commit_c) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (commit_c) begin
            misalign_d = mis_c;
            if (!cur_write_c && !mis_c) begin
                rdata_d = load_val_c;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lsig_q     <= '0;
            ssig_q     <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lsig_q     <= lsig_d;
            ssig_q     <= ssig_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
        end
    end

    // Backing word array; contents survive reset.
    always_ff @(posedge CLK) begin
        if (mem_we_c) begin
            mem_q[cur_addr_c[BA_W-1:2]] <= merged_c;
        end
    end

    // Stall is combinational in IDLE so the requester sees it in the request cycle.
    assign BUSYWAIT = RESET && (((state_q == IDLE) && req_c) || (state_q == ACCESS));
    assign READDATA = rdata_q;
    assign MISALIGN = misalign_q;

endmodule
